// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared constants and types for the register hazard scoreboard: MIPS-style opcode/funct
// encodings, the scoreboard entry layout and the forwarding-select encoding.
package reg_hazard_scoreboard_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] OP_LB       = 6'h20;
  localparam logic [5:0] OP_LH       = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_SB       = 6'h28;
  localparam logic [5:0] OP_SH       = 6'h29;
  localparam logic [5:0] OP_SW       = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_MUL = 6'h02;

  localparam logic [3:0] FWD_REGFILE = 4'd0;
  localparam int unsigned LAT_W = 4;

  typedef struct packed {
    logic             valid;
    logic [4:0]       dest;
    logic [LAT_W-1:0] lat;
  } sb_entry_t;

  function automatic logic is_alu_funct(logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLL, FN_SRL, FN_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_if.sv
// ID-stage hazard interface: the pipeline (master) presents the ID instruction, the
// scoreboard (slave) answers with stall, forwarding selects and the stall counter.
interface reg_hazard_scoreboard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      instr_id;
  logic             instr_valid;
  logic             flush;
  logic             stall;
  logic [3:0]       fwd_sel_a;
  logic [3:0]       fwd_sel_b;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output instr_id, instr_valid, flush,
    input  stall, fwd_sel_a, fwd_sel_b, stall_count
  );

  modport slave (
    input  instr_id, instr_valid, flush,
    output stall, fwd_sel_a, fwd_sel_b, stall_count
  );
endinterface

// File: rtl/reg_use_decoder.sv
// Combinational decode of which source registers an instruction reads, which register it
// writes and how many stages pass before that result can be forwarded.
module reg_use_decoder
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned MUL_LAT  = 2
) (
  input  logic [31:0]      i_instr,
  output logic             o_rs_used,
  output logic             o_rt_used,
  output logic [4:0]       o_dest,
  output logic             o_dest_valid,
  output logic [LAT_W-1:0] o_ready_lat
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic [4:0] w_rt;
  logic [4:0] w_rd;
  logic       w_is_zero;
  logic       w_has_dest;

  assign w_op      = i_instr[31:26];
  assign w_funct   = i_instr[5:0];
  assign w_rt      = i_instr[20:16];
  assign w_rd      = i_instr[15:11];
  assign w_is_zero = (i_instr == 32'h0);

  always_comb begin
    o_rs_used   = !w_is_zero && (w_op != OP_J) && (w_op != OP_JAL);
    o_rt_used   = 1'b0;
    o_dest      = 5'd0;
    w_has_dest  = 1'b0;
    o_ready_lat = LAT_W'(1);
    case (w_op)
      OP_SPECIAL: begin
        if (is_alu_funct(w_funct)) begin
          o_rt_used  = !w_is_zero;
          o_dest     = w_rd;
          w_has_dest = 1'b1;
        end
      end
      OP_SPECIAL2: begin
        if (w_funct == FN_MUL) begin
          o_rt_used   = 1'b1;
          o_dest      = w_rd;
          w_has_dest  = 1'b1;
          o_ready_lat = LAT_W'(MUL_LAT);
        end
      end
      OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE: o_rt_used = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        o_dest     = w_rt;
        w_has_dest = 1'b1;
      end
      OP_LW, OP_LH, OP_LB: begin
        o_dest      = w_rt;
        w_has_dest  = 1'b1;
        o_ready_lat = LAT_W'(LOAD_LAT);
      end
      OP_JAL: begin
        o_dest     = 5'd31;
        w_has_dest = 1'b1;
      end
      default: ;
    endcase
  end

  // A write to $0 is architecturally discarded, so it never creates a hazard.
  assign o_dest_valid = w_has_dest && (o_dest != 5'd0);

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// ID-stage hazard unit: a shift scoreboard of in-flight destination writes (entry 0 = EX)
// drives the ID stall, per-operand forwarding selects and a saturating stall counter.
module reg_hazard_scoreboard
  import reg_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned LOAD_LAT   = 2,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  reg_hazard_scoreboard_if.slave io_bus
);

  sb_entry_t        r_sb [PIPE_DEPTH];
  logic [CNT_W-1:0] r_stall_count;

  logic             w_rs_used;
  logic             w_rt_used;
  logic [4:0]       w_dest;
  logic             w_dest_valid;
  logic [LAT_W-1:0] w_ready_lat;

  logic [4:0]       w_src      [2];
  logic             w_used     [2];
  logic             w_hit      [2];
  logic [3:0]       w_hit_k    [2];
  logic [LAT_W-1:0] w_hit_lat  [2];
  logic             w_op_stall [2];
  logic [3:0]       w_op_sel   [2];
  logic             w_stall;
  logic             w_issue;

  reg_use_decoder #(
    .LOAD_LAT(LOAD_LAT),
    .MUL_LAT (MUL_LAT)
  ) u_decoder (
    .i_instr     (io_bus.instr_id),
    .o_rs_used   (w_rs_used),
    .o_rt_used   (w_rt_used),
    .o_dest      (w_dest),
    .o_dest_valid(w_dest_valid),
    .o_ready_lat (w_ready_lat)
  );

  always_comb begin
    w_src[0]  = io_bus.instr_id[25:21];
    w_src[1]  = io_bus.instr_id[20:16];
    w_used[0] = w_rs_used && (w_src[0] != 5'd0);
    w_used[1] = w_rt_used && (w_src[1] != 5'd0);
    for (int o = 0; o < 2; o++) begin
      w_hit[o]      = 1'b0;
      w_hit_k[o]    = 4'd0;
      w_hit_lat[o]  = '0;
      // Scan oldest to youngest so the youngest match overwrites; the last entry is
      // excluded because the register file is write-first.
      for (int k = int'(PIPE_DEPTH) - 2; k >= 0; k--) begin
        if (r_sb[k].valid && (r_sb[k].dest == w_src[o])) begin
          w_hit[o]     = 1'b1;
          w_hit_k[o]   = 4'(k);
          w_hit_lat[o] = r_sb[k].lat;
        end
      end
      w_op_stall[o] = 1'b0;
      w_op_sel[o]   = FWD_REGFILE;
      if (w_used[o] && w_hit[o]) begin
        if (FWD_EN == 0) begin
          w_op_stall[o] = 1'b1;
        end else if ((5'(w_hit_k[o]) + 5'd1) < 5'(w_hit_lat[o])) begin
          w_op_stall[o] = 1'b1;
        end else begin
          w_op_sel[o] = w_hit_k[o] + 4'd1;
        end
      end
    end
  end

  assign w_stall = io_bus.instr_valid && !io_bus.flush && (w_op_stall[0] || w_op_stall[1]);
  assign w_issue = io_bus.instr_valid && !io_bus.flush && !w_stall;

  assign io_bus.stall       = w_stall;
  assign io_bus.fwd_sel_a   = w_stall ? FWD_REGFILE : w_op_sel[0];
  assign io_bus.fwd_sel_b   = w_stall ? FWD_REGFILE : w_op_sel[1];
  assign io_bus.stall_count = r_stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
        r_sb[k] <= '0;
      end
      r_stall_count <= '0;
    end else begin
      if (w_issue) begin
        r_sb[0] <= '{valid: w_dest_valid, dest: w_dest, lat: w_ready_lat};
      end else begin
        r_sb[0] <= '0;
      end
      for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
        r_sb[k] <= r_sb[k-1];
      end
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Scoreboard bench: directed instruction sequences push expected outputs into per-DUT
// queues; a monitor pops and compares on each falling edge (or on an explicit strobe).
module tb_reg_hazard_scoreboard;

  typedef struct {
    logic        stall;
    logic [3:0]  a;
    logic [3:0]  b;
    int unsigned cnt;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n, rst1_n, rst2_n;
  logic chk_tgl = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  reg_hazard_scoreboard_if #(.CNT_W(16)) bus0 ();
  reg_hazard_scoreboard_if #(.CNT_W(16)) bus1 ();
  reg_hazard_scoreboard_if #(.CNT_W(4))  bus2 ();

  reg_hazard_scoreboard #(
    .PIPE_DEPTH(3), .LOAD_LAT(2), .MUL_LAT(2), .FWD_EN(1), .CNT_W(16)
  ) dut0 (.i_clk(clk), .i_rst_n(rst0_n), .io_bus(bus0));

  reg_hazard_scoreboard #(
    .PIPE_DEPTH(3), .LOAD_LAT(2), .MUL_LAT(2), .FWD_EN(0), .CNT_W(16)
  ) dut1 (.i_clk(clk), .i_rst_n(rst1_n), .io_bus(bus1));

  reg_hazard_scoreboard #(
    .PIPE_DEPTH(8), .LOAD_LAT(2), .MUL_LAT(2), .FWD_EN(0), .CNT_W(4)
  ) dut2 (.i_clk(clk), .i_rst_n(rst2_n), .io_bus(bus2));

  task automatic drive(int d, logic [31:0] ins, logic v, logic f);
    case (d)
      0: begin bus0.instr_id = ins; bus0.instr_valid = v; bus0.flush = f; end
      1: begin bus1.instr_id = ins; bus1.instr_valid = v; bus1.flush = f; end
      default: begin bus2.instr_id = ins; bus2.instr_valid = v; bus2.flush = f; end
    endcase
  endtask

  task automatic push(int d, logic s, logic [3:0] a, logic [3:0] b, int unsigned c,
                      string nm);
    exp_t e;
    e.stall = s;
    e.a     = a;
    e.b     = b;
    e.cnt   = c;
    e.name  = nm;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic step(int d, logic [31:0] ins, logic v, logic f, logic s, logic [3:0] a,
                      logic [3:0] b, int unsigned c, string nm);
    @(posedge clk);
    #1;
    drive(d, ins, v, f);
    push(d, s, a, b, c, nm);
  endtask

  task automatic compare(int d, exp_t e);
    logic        s;
    logic [3:0]  a, b;
    int unsigned c;
    case (d)
      0: begin s = bus0.stall; a = bus0.fwd_sel_a; b = bus0.fwd_sel_b;
               c = 32'(bus0.stall_count); end
      1: begin s = bus1.stall; a = bus1.fwd_sel_a; b = bus1.fwd_sel_b;
               c = 32'(bus1.stall_count); end
      default: begin s = bus2.stall; a = bus2.fwd_sel_a; b = bus2.fwd_sel_b;
               c = 32'(bus2.stall_count); end
    endcase
    n_tests++;
    if (s !== e.stall || a !== e.a || b !== e.b || c != e.cnt) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got stall=%0b fwd_a=%0d fwd_b=%0d count=%0d, want stall=%0b fwd_a=%0d fwd_b=%0d count=%0d",
               e.name, d, s, a, b, c, e.stall, e.a, e.b, e.cnt);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or chk_tgl);
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
      if (q2.size() > 0) compare(2, q2.pop_front());
    end
  end

  // Forwarding build: load-use, ALU chain, $0, flush, mul, async reset mid-stall.
  task automatic seq0();
    step(0, 32'h8D280000, 1, 0, 0, 0, 0, 0, "lw issue");
    step(0, 32'h010B5020, 1, 0, 1, 0, 0, 0, "load-use stall");
    step(0, 32'h010B5020, 1, 0, 0, 2, 0, 1, "load-use fwd");
    step(0, 32'h014A6022, 1, 0, 0, 1, 1, 1, "alu chain");
    step(0, 32'h21000005, 1, 0, 0, 0, 0, 1, "write r0");
    step(0, 32'h00006820, 1, 0, 0, 0, 0, 1, "read r0");
    step(0, 32'h00000000, 1, 0, 0, 0, 0, 1, "nop");
    step(0, 32'h8D280000, 1, 0, 0, 0, 0, 1, "lw before flush");
    step(0, 32'h010B5020, 1, 1, 0, 0, 0, 1, "flush wins");
    step(0, 32'h01487025, 1, 0, 0, 0, 2, 1, "after flush");
    step(0, 32'h71095002, 1, 0, 0, 0, 0, 1, "mul issue");
    step(0, 32'h014A6022, 1, 0, 1, 0, 0, 1, "mul-use stall");
    step(0, 32'h014A6022, 1, 0, 0, 2, 2, 2, "mul-use fwd");
    step(0, 32'h8D280000, 1, 0, 0, 0, 0, 2, "lw before reset");
    step(0, 32'h010B5020, 1, 0, 1, 0, 0, 2, "stall before reset");
    @(negedge clk);
    #2;
    rst0_n = 1'b0;
    #1;
    push(0, 0, 0, 0, 0, "async reset");
    chk_tgl = ~chk_tgl;
    @(posedge clk);
    #1;
    rst0_n = 1'b1;
    step(0, 32'h010B5020, 1, 0, 0, 0, 0, 0, "after reset");
    step(0, 32'h014A6022, 1, 0, 0, 1, 1, 0, "chain after reset");
    step(0, 32'h00000000, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  // Stall-only build: dependent ALU op waits until the producer reaches WB.
  task automatic seq1();
    step(1, 32'h010B5020, 1, 0, 0, 0, 0, 0, "nofwd add");
    step(1, 32'h014A6022, 1, 0, 1, 0, 0, 0, "nofwd stall 1");
    step(1, 32'h014A6022, 1, 0, 1, 0, 0, 1, "nofwd stall 2");
    step(1, 32'h014A6022, 1, 0, 0, 0, 0, 2, "nofwd issue");
    step(1, 32'h01806820, 1, 0, 1, 0, 0, 2, "nofwd sub issued");
    step(1, 32'h00000000, 0, 0, 0, 0, 0, 3, "nofwd idle");
  endtask

  // Deep stall-only build with a 4-bit counter: self-dependent add saturates the count.
  task automatic seq2();
    int unsigned cnt;
    logic        s;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      s = ((i % 8) != 0);
      step(2, 32'h014A5020, 1, 0, s, 0, 0, cnt, "saturate");
      if (s && cnt != 15) cnt++;
    end
    step(2, 32'h00000000, 0, 0, 0, 0, 0, 15, "saturated hold");
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      drive(d, 32'h0, 1'b0, 1'b0);
      push(d, 0, 0, 0, 0, "reset state");
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    fork
      seq0();
      seq1();
      seq2();
    join
    @(negedge clk);
    #1;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      n_fail++;
      $display("FAIL unchecked: %0d expectations left, want 0",
               q0.size() + q1.size() + q2.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
